// File: rtl/paddle_emulator.sv
// Purpose: emulates RC/555 paddle comparators, raising hpaddle/vpaddle on the scanline equal to the X/Y position.
// Latency: line_cnt 1 cycle after hsync rise; paddle 1 cycle after line_cnt reaches position; frame_tick 1 cycle after vsync rise.
// Backpressure: none, free-running on video timing. Optional PADDLE_SLEW_EN limits per-frame position movement to MAX_STEP.
module paddle_emulator #(
    parameter int unsigned       LINE_W   = 16,
    parameter logic [LINE_W-1:0] SAT_LINE = 16'd262,
    parameter logic [LINE_W-1:0] MAX_STEP = 16'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [LINE_W-1:0] pos_x,
    input  logic [LINE_W-1:0] pos_y,
    output logic              hpaddle,
    output logic              vpaddle,
    output logic [LINE_W-1:0] line_cnt,
    output logic              frame_tick
);

`ifdef PADDLE_SLEW_EN
    localparam logic SLEW_ON = 1'b1;
`else
    localparam logic SLEW_ON = 1'b0;
`endif

    // Without slew the step limit is effectively unbounded, so eff jumps straight to pos.
    localparam logic [LINE_W-1:0] STEP_LIM = SLEW_ON ? MAX_STEP : {LINE_W{1'b1}};

    typedef enum logic {
        SYNC = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              hs_q;
    logic              vs_q;
    logic              vs_rise;
    logic              vs_fall;
    logic              hs_rise;
    logic [LINE_W-1:0] eff_x;
    logic [LINE_W-1:0] eff_y;
    logic [LINE_W-1:0] eff_x_nxt;
    logic [LINE_W-1:0] eff_y_nxt;

    assign vs_rise = vsync & ~vs_q;
    assign vs_fall = ~vsync & vs_q;
    assign hs_rise = hsync & ~hs_q;

    // Move eff toward pos by at most STEP_LIM, never overshooting pos.
    function automatic logic [LINE_W-1:0] step_toward(input logic [LINE_W-1:0] pos,
                                                      input logic [LINE_W-1:0] eff);
        logic [LINE_W-1:0] res;
        if (pos >= eff) begin
            res = ((pos - eff) > STEP_LIM) ? (eff + STEP_LIM) : pos;
        end else begin
            res = ((eff - pos) > STEP_LIM) ? (eff - STEP_LIM) : pos;
        end
        return res;
    endfunction

    // Effective positions to be latched at the next frame start.
    always_comb begin
        eff_x_nxt = step_toward(pos_x, eff_x);
        eff_y_nxt = step_toward(pos_y, eff_y);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: vsync falling opens the scan, vsync rising closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (vs_fall) state_d = SCAN;
            SCAN:    if (vs_rise) state_d = SYNC;
            default: state_d = SYNC;
        endcase
    end

    // Sync edge registers, line counter, frame start and registered comparators.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            line_cnt   <= '0;
            hpaddle    <= 1'b0;
            vpaddle    <= 1'b0;
            frame_tick <= 1'b0;
            eff_x      <= '0;
            eff_y      <= '0;
        end else begin
            hs_q       <= hsync;
            vs_q       <= vsync;
            frame_tick <= vs_rise;
            if (vs_rise) begin
                // Frame start takes priority over a coincident hsync edge.
                line_cnt <= '0;
                hpaddle  <= 1'b0;
                vpaddle  <= 1'b0;
                eff_x    <= eff_x_nxt;
                eff_y    <= eff_y_nxt;
            end else if (state_q == SYNC) begin
                line_cnt <= '0;
                hpaddle  <= 1'b0;
                vpaddle  <= 1'b0;
            end else begin
                if (hs_rise && (line_cnt < SAT_LINE)) begin
                    line_cnt <= line_cnt + LINE_W'(1);
                end
                hpaddle <= (line_cnt >= eff_x);
                vpaddle <= (line_cnt >= eff_y);
            end
        end
    end

endmodule

// File: tb/tb_paddle_emulator.sv
// Purpose: randomized scoreboard bench for paddle_emulator; a frame-level model predicts event cycles.
// Latency: expected paddle rises, frame ticks and last line counts are queued at stimulus time.
// Backpressure: none; a negedge monitor pops and compares whenever the DUT shows an event.
module tb_paddle_emulator;
    localparam int SAT      = 262;
    localparam int MAX_STEP = 4;
`ifdef PADDLE_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [15:0] pos_x = '0;
    logic [15:0] pos_y = '0;
    logic        hpaddle;
    logic        vpaddle;
    logic [15:0] line_cnt;
    logic        frame_tick;

    paddle_emulator #(
        .LINE_W  (16),
        .SAT_LINE(16'd262),
        .MAX_STEP(16'd4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hsync     (hsync),
        .vsync     (vsync),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .hpaddle   (hpaddle),
        .vpaddle   (vpaddle),
        .line_cnt  (line_cnt),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int at;
        int last;
    } ft_t;

    int  exp_h[$];
    int  exp_v[$];
    ft_t exp_ft[$];

    // Reference model: frame-level view of the paddle circuit.
    bit m_scan;
    bit m_vs;
    bit m_hs;
    int m_cnt;
    int m_eff_x;
    int m_eff_y;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int slew_to(input int pos, input int eff);
        int d;
        if (!SLEW) return pos;
        d = pos - eff;
        if (d > MAX_STEP) return eff + MAX_STEP;
        if (d < -MAX_STEP) return eff - MAX_STEP;
        return pos;
    endfunction

    // Drive one cycle of sync inputs and predict resulting events.
    task automatic step(input bit hs, input bit vs);
        int  k;
        int  old;
        ft_t e;
        k = cyc;
        hsync = hs;
        vsync = vs;
        if (vs && !m_vs) begin
            e.at   = k + 1;
            e.last = m_cnt;
            exp_ft.push_back(e);
            m_cnt   = 0;
            m_scan  = 1'b0;
            m_eff_x = slew_to(int'(pos_x), m_eff_x);
            m_eff_y = slew_to(int'(pos_y), m_eff_y);
        end else if (!vs && m_vs) begin
            m_scan = 1'b1;
            m_cnt  = 0;
            if (m_eff_x == 0) exp_h.push_back(k + 2);
            if (m_eff_y == 0) exp_v.push_back(k + 2);
        end else if (m_scan && hs && !m_hs) begin
            old = m_cnt;
            if (m_cnt < SAT) m_cnt++;
            if (old < m_eff_x && m_cnt >= m_eff_x) exp_h.push_back(k + 2);
            if (old < m_eff_y && m_cnt >= m_eff_y) exp_v.push_back(k + 2);
        end
        m_vs = vs;
        m_hs = hs;
        @(negedge clk);
    endtask

    task automatic do_reset();
        hsync = 1'b0;
        vsync = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_line_cnt", int'(line_cnt), 0);
        check("reset_hpaddle", int'(hpaddle), 0);
        check("reset_vpaddle", int'(vpaddle), 0);
        check("reset_frame_tick", int'(frame_tick), 0);
        reset   = 1'b0;
        m_scan  = 1'b0;
        m_cnt   = 0;
        m_eff_x = 0;
        m_eff_y = 0;
        m_vs    = 1'b0;
        m_hs    = 1'b0;
    endtask

    // One frame: vsync pulse, then nlines hsync pulses with random spacing.
    task automatic frame(input int nlines, input bit simul, input int chg_line,
                         input int chg_x, input int rst_line);
        step(simul, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < nlines; i++) begin
            if (i == chg_line) pos_x = 16'(chg_x);
            if (i == rst_line) begin
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
                do_reset();
            end
            step(1'b1, 1'b0);
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0);
    endtask

    function automatic int rand_pos();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return int'($urandom_range(1, 60));
            2:       return int'($urandom_range(60, 250));
            3:       return int'($urandom_range(255, 262));
            default: return int'($urandom_range(263, 400));
        endcase
    endfunction

    // Monitor: compare every DUT event against the head of its expectation queue.
    logic h_prev = 1'b0;
    logic v_prev = 1'b0;
    int   lc_prev = 0;
    always @(negedge clk) begin
        ft_t e;
        int  x;
        if (!reset) begin
            if (hpaddle && !h_prev) begin
                n_tests++;
                if (exp_h.size() == 0) begin
                    n_fail++;
                    $display("FAIL hpaddle_rise: rose at cycle %0d, expected no rise", cyc);
                end else begin
                    x = exp_h.pop_front();
                    if (x != cyc) begin
                        n_fail++;
                        $display("FAIL hpaddle_rise: rose at cycle %0d, expected cycle %0d", cyc, x);
                    end
                end
            end
            if (vpaddle && !v_prev) begin
                n_tests++;
                if (exp_v.size() == 0) begin
                    n_fail++;
                    $display("FAIL vpaddle_rise: rose at cycle %0d, expected no rise", cyc);
                end else begin
                    x = exp_v.pop_front();
                    if (x != cyc) begin
                        n_fail++;
                        $display("FAIL vpaddle_rise: rose at cycle %0d, expected cycle %0d", cyc, x);
                    end
                end
            end
            if (frame_tick) begin
                n_tests++;
                if (exp_ft.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_tick: pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_ft.pop_front();
                    if (e.at != cyc) begin
                        n_fail++;
                        $display("FAIL frame_tick: pulse at cycle %0d, expected cycle %0d", cyc, e.at);
                    end
                    check("frame_last_line_cnt", lc_prev, e.last);
                end
                check("ft_line_cnt_zero", int'(line_cnt), 0);
                check("ft_hpaddle_low", int'(hpaddle), 0);
                check("ft_vpaddle_low", int'(vpaddle), 0);
            end
        end
        h_prev  <= hpaddle;
        v_prev  <= vpaddle;
        lc_prev <= int'(line_cnt);
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Basic frame.
        pos_x = 16'd10;
        pos_y = 16'd100;
        frame(262, 1'b0, -1, 0, -1);

        // Position 0 and out of range, with saturation of the line counter.
        pos_x = 16'd0;
        pos_y = 16'd300;
        frame(280, 1'b0, -1, 0, -1);

        // Mid-frame change of pos_x takes effect only next frame.
        pos_x = 16'd50;
        pos_y = 16'd5;
        frame(60, 1'b0, 30, 20, -1);
        frame(60, 1'b0, -1, 0, -1);

        // Coincident hsync and vsync rising edges.
        frame(30, 1'b1, -1, 0, -1);
        frame(30, 1'b1, -1, 0, -1);

        // Reset mid-frame with vsync low, then normal frames resume.
        pos_x = 16'd30;
        pos_y = 16'd60;
        frame(70, 1'b0, -1, 0, 40);
        frame(70, 1'b0, -1, 0, -1);

        // Position step 0 -> 10 (gradual when slew is enabled).
        pos_x = 16'd0;
        pos_y = 16'd0;
        repeat (3) frame(20, 1'b0, -1, 0, -1);
        pos_x = 16'd10;
        repeat (3) frame(20, 1'b0, -1, 0, -1);

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            int nl;
            int rl;
            nl    = int'($urandom_range(5, 280));
            pos_x = 16'(rand_pos());
            pos_y = 16'(rand_pos());
            rl    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            frame(nl, ($urandom_range(0, 3) == 0), int'($urandom_range(0, nl)), rand_pos(), rl);
        end

        // Close the last frame so its line count is checked.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);

        check("leftover_hpaddle_events", exp_h.size(), 0);
        check("leftover_vpaddle_events", exp_v.size(), 0);
        check("leftover_frame_ticks", exp_ft.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_emulator.md
# paddle_emulator

Generates the paddle comparator signals `hpaddle` / `vpaddle` from digital X/Y positions. The paddle reader latches the current scanline number on each rising edge of these signals. This block is the transmitting end of that interface. It sits between a digital position source (buttons, encoder, or CPU register) and any paddle-reading logic. It counts scanlines from `hsync` and `vsync` and raises each paddle line on the scanline equal to its position, the way an RC/555 paddle circuit does. All logic is in one clock domain. `hsync` and `vsync` are active-high pulses from `hvsync_generator` in the same clock domain.

## Interface
- `LINE_W`, 16, width of the positions and the line counter
- `SAT_LINE`, 16'd262, saturation value of the line counter
- `MAX_STEP`, 16'd4, maximum change in the effective position per frame (used only with `PADDLE_SLEW_EN`)

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `hsync`  in  1  horizontal sync, active high
- `vsync`  in  1  vertical sync, active high
- `pos_x`  in  LINE_W  requested horizontal paddle scanline
- `pos_y`  in  LINE_W  requested vertical paddle scanline
- `hpaddle`  out  1  horizontal paddle comparator output
- `vpaddle`  out  1  vertical paddle comparator output
- `line_cnt`  out  LINE_W  scanlines counted since `vsync` fell (debug)
- `frame_tick`  out  1  one-cycle pulse on the `vsync` rising edge

## Operation
- **Edge detect:** `hsync` and `vsync` are registered into `hs_q` and `vs_q`.
  - `vs_rise` = `vsync & ~vs_q`
  - `vs_fall` = `~vsync & vs_q`
  - `hs_rise` = `hsync & ~hs_q`
- **State machine:** two states, SYNC and SCAN.
  - SYNC → SCAN on `vs_fall`.
  - SCAN → SYNC on `vs_rise`.
  - SYNC ignores `vs_rise`.
- **On `vs_rise` (from either state):**
  - `line_cnt` ← 0
  - `hpaddle` and `vpaddle` ← 0
  - `frame_tick` ← 1 for one cycle
  - `eff_x` ← update(`pos_x`, `eff_x`) and `eff_y` ← update(`pos_y`, `eff_y`); see Configuration.
- **In SYNC:**
  - `line_cnt` is held at 0.
  - Both paddle outputs are held at 0.
  - `hs_rise` is ignored.
- **In SCAN:**
  - `hs_rise` increments `line_cnt`, saturating at `SAT_LINE`.
  - `hpaddle` ← (`line_cnt` >= `eff_x`) and `vpaddle` ← (`line_cnt` >= `eff_y`), both registered.
  - Each output is therefore monotonic within a frame: it rises once and stays high until the next `vs_rise`.
- **Out-of-range position:** if `eff` > `SAT_LINE`, that output never rises in the frame.
- **Arithmetic:** all unsigned, `LINE_W` bits, with no wrap.
- **Position sampling:** `pos_x` and `pos_y` are sampled only on `vs_rise`. Mid-frame changes have no effect until the next frame.
- **`vs_rise` and `hs_rise` in the same cycle:** `vs_rise` wins. The counter resets and the `hsync` edge is discarded.

## Timing
- **Reset values:**
  - state = SYNC
  - `line_cnt` = 0, `hpaddle` = 0, `vpaddle` = 0, `frame_tick` = 0
  - `eff_x` = 0, `eff_y` = 0
  - `hs_q` = 0, `vs_q` = 0
- **Reset asserted mid-frame with `vsync` low:** no `vs_fall` is seen, so the block stays in SYNC with outputs low until the next full `vsync` pulse.
- **`frame_tick`:** high in the cycle after the first cycle `vsync` is sampled high.
- **`line_cnt`:** updates one cycle after the `hsync` input is first sampled high.
- **Paddle latency:** a paddle output rises one cycle after `line_cnt` reaches `eff`. That is two cycles after the `hsync` edge that completes the count.
- **Position 0:** the output rises two cycles after `vsync` is first sampled low (one cycle to enter SCAN, one cycle for the compare register).
- **Falling edge:** paddle outputs fall one cycle after `vsync` is first sampled high, in the same cycle `frame_tick` is high.

## Configuration
- `PADDLE_SLEW_EN` defined: on each `vs_rise`, `eff` moves toward `pos` by min(|`pos` − `eff`|, `MAX_STEP`). This smooths jitter from the position source.
- `PADDLE_SLEW_EN` undefined: `eff` ← `pos` directly on each `vs_rise`. `MAX_STEP` is unused.

## Test plan
- **Basic frame:** reset, then `pos_x`=10, `pos_y`=100, one frame of 262 lines → `hpaddle` rises 2 cycles after the 10th `hsync` edge following the `vsync` fall, and `vpaddle` after the 100th. Both fall with the next `frame_tick`.
- **Position 0 and out of range:** `pos_x`=0, `pos_y`=300 → `hpaddle` high 2 cycles after `vsync` falls. `vpaddle` stays low all frame, and `line_cnt` saturates at 262.
- **Mid-frame change:** change `pos_x` from 50 to 20 at line 30 → `hpaddle` still rises at line 50 this frame and at line 20 in the next frame (slew off).
- **Simultaneous edges:** `hsync` and `vsync` rise in the same cycle → `line_cnt` = 0, `frame_tick` = 1, and no increment occurs.
- **Reset mid-frame:** reset at line 40 with `vsync` low → outputs stay 0 until a full `vsync` pulse, then normal counting resumes.
- **Slew:** with `PADDLE_SLEW_EN`, `MAX_STEP`=4, `pos_x` stepped from 0 to 10 → `hpaddle` rise line is 4, 8, 10 over three consecutive frames.
